// File: rtl/vscpu_ram_loader_if.sv
// CPU RAM port plus byte-serial boot-loader handshake for vscpu_ram_loader.
// master: CPU core and loader host; slave: the memory/loader block.
interface vscpu_ram_loader_if #(
    parameter int SIZE = 14
);
    // CPU RAM port
    logic            wrEn;
    logic [SIZE-1:0] addr_toRAM;
    logic [31:0]     data_toRAM;
    logic [31:0]     data_fromRAM;
    logic            cpu_rst;

    // Loader control and status
    logic            ld_start;
    logic            ld_run;
    logic [SIZE-1:0] ld_count;
    logic [7:0]      ld_byte;
    logic            ld_valid;
    logic            ld_ready;
    logic            ld_done;
    logic [31:0]     ld_sum;
    logic            wp_hit;

    modport master (
        output wrEn, addr_toRAM, data_toRAM,
        output ld_start, ld_run, ld_count, ld_byte, ld_valid,
        input  data_fromRAM, cpu_rst, ld_ready, ld_done, ld_sum, wp_hit
    );

    modport slave (
        input  wrEn, addr_toRAM, data_toRAM,
        input  ld_start, ld_run, ld_count, ld_byte, ld_valid,
        output data_fromRAM, cpu_rst, ld_ready, ld_done, ld_sum, wp_hit
    );
endinterface

// File: rtl/vscpu_ram_loader.sv
// VerySimpleCPU program/data RAM with byte-serial boot loader holding the CPU in reset.
// Optional CPU write protection of the low PROT_TOP words: define VSCPU_WR_PROTECT_EN.
module vscpu_ram_loader #(
    parameter int SIZE     = 14,
    parameter int PROT_TOP = 16
) (
    input logic               clk,
    input logic               rst,
    vscpu_ram_loader_if.slave bus
);

`ifdef VSCPU_WR_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif
    localparam logic [SIZE-1:0] PROT_LIM = SIZE'(PROT_TOP);

    typedef enum logic [1:0] {HOLD, LOAD, RUN} state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] count_q;
    logic [SIZE-1:0] waddr_q;
    logic [1:0]      byte_cnt_q;
    logic [23:0]     shift_q;
    logic [31:0]     sum_q;
    logic            done_q;
    logic            cpu_rst_q;
    logic            wp_hit_q;
    logic [31:0]     rd_q;

    logic [31:0]     mem [0:(2**SIZE)-1];

    logic            start_go;
    logic            ld_ready;
    logic            byte_acc;
    logic            word_acc;
    logic            last_word;
    logic [SIZE-1:0] waddr_inc;
    logic [31:0]     word;
    logic            cpu_wr;
    logic            cpu_block;
    logic            mem_we;
    logic [SIZE-1:0] mem_addr;
    logic [31:0]     mem_wdata;

    // ld_start is honoured in HOLD and RUN only; it beats ld_run in HOLD.
    assign start_go  = bus.ld_start && (state_q != LOAD);
    assign ld_ready  = (state_q == LOAD) && (count_q != '0);
    assign byte_acc  = bus.ld_valid && ld_ready;
    assign word_acc  = byte_acc && (byte_cnt_q == 2'd3);
    assign waddr_inc = waddr_q + 1'b1;
    assign last_word = word_acc && (waddr_inc == count_q);
    assign word      = {shift_q, bus.ld_byte};

    assign cpu_wr    = (state_q == RUN) && bus.wrEn;
    assign cpu_block = WP_EN && (bus.addr_toRAM < PROT_LIM);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= HOLD;
        else      state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD: begin
                if (start_go)         state_d = LOAD;
                else if (bus.ld_run)  state_d = RUN;
            end
            LOAD: begin
                if ((count_q == '0) || last_word) state_d = HOLD;
            end
            RUN: begin
                if (start_go) state_d = LOAD;
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            waddr_q    <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            sum_q      <= '0;
            done_q     <= 1'b0;
            cpu_rst_q  <= 1'b1;
            wp_hit_q   <= 1'b0;
        end else begin
            cpu_rst_q <= (state_d != RUN);
            if (start_go) begin
                count_q    <= bus.ld_count;
                waddr_q    <= '0;
                byte_cnt_q <= '0;
                sum_q      <= '0;
                done_q     <= 1'b0;
                wp_hit_q   <= 1'b0;
            end else begin
                if ((state_q == LOAD) && (count_q == '0)) done_q <= 1'b1;
                if (byte_acc) begin
                    if (byte_cnt_q == 2'd3) begin
                        waddr_q    <= waddr_inc;
                        sum_q      <= sum_q + word;
                        byte_cnt_q <= '0;
                        if (last_word) done_q <= 1'b1;
                    end else begin
                        shift_q    <= {shift_q[15:0], bus.ld_byte};
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    end
                end
                if (cpu_wr && cpu_block) wp_hit_q <= 1'b1;
            end
        end
    end

    // Single write port: the loader owns it in LOAD, the CPU in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = waddr_q;
        mem_wdata = word;
        if (word_acc) begin
            mem_we = 1'b1;
        end else if (cpu_wr && !cpu_block) begin
            mem_we    = 1'b1;
            mem_addr  = bus.addr_toRAM;
            mem_wdata = bus.data_toRAM;
        end
    end

    // NOTE: the memory array has no reset; only the read register around it does.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Reading the array at the same edge as a write returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_q <= '0;
        else      rd_q <= mem[bus.addr_toRAM];
    end

    assign bus.data_fromRAM = (state_q == RUN) ? rd_q : '0;
    assign bus.cpu_rst      = cpu_rst_q;
    assign bus.ld_ready     = ld_ready;
    assign bus.ld_done      = done_q;
    assign bus.ld_sum       = sum_q;
    assign bus.wp_hit       = wp_hit_q;

endmodule
